// File: rtl/mcse_secure_mem_ctrl.sv
// Multi-channel secure memory controller: round-robin arbitration of NUM_CH clients onto one
// word array, with sticky per-word locks, lifecycle-gated secret reads and a zeroize sequencer.
module mcse_secure_mem_ctrl #(
  parameter int         NUM_CH      = 3,
  parameter int         WIDTH       = 256,
  parameter int         LENGTH      = 16,
  parameter int         SECRET_BASE = 8,
  parameter logic [2:0] LC_DEBUG    = 3'd4,
  localparam int        AW          = (LENGTH > 1) ? $clog2(LENGTH) : 1,
  localparam int        CW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_req,
  input  logic [NUM_CH-1:0]       ch_we,
  input  logic [NUM_CH-1:0]       ch_lock,
  input  logic [NUM_CH*AW-1:0]    ch_addr,
  input  logic [NUM_CH*WIDTH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]       ch_gnt,
  input  logic [2:0]              lc_state,
  input  logic                    zeroize,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_valid,
  output logic [CW-1:0]           rsp_ch,
  output logic                    err,
  output logic [1:0]              err_code,
  output logic                    busy,
  output logic                    zero_done
);

  localparam int             CW1         = CW + 1;
  localparam logic [AW-1:0]  LAST_WORD   = AW'(LENGTH - 1);
  localparam logic [1:0]     CODE_RANGE  = 2'b00;
  localparam logic [1:0]     CODE_LOCKED = 2'b01;
  localparam logic [1:0]     CODE_DEBUG  = 2'b10;
  localparam logic [1:0]     CODE_PRIV   = 2'b11;

  typedef enum logic {IDLE = 1'b0, ZERO = 1'b1} state_t;

  state_t              state_r, state_s;
  logic [AW-1:0]       zcnt_r, zcnt_s;
  logic [CW-1:0]       rr_r;
  logic [LENGTH-1:0]   lock_r;
  logic [WIDTH-1:0]    mem_r [LENGTH];

  logic                gnt_valid_s;
  logic [CW-1:0]       gnt_idx_s;
  logic [NUM_CH-1:0]   gnt_s;
  logic [CW:0]         sum_s;
  logic [CW-1:0]       cand_s;

  logic [AW-1:0]       sel_addr_s;
  logic                sel_we_s;
  logic                sel_lock_s;
  logic [WIDTH-1:0]    sel_wdata_s;
  logic [31:0]         addr_ext_s;
  logic                acc_err_s;
  logic [1:0]          acc_code_s;
  logic                zero_last_s;

  assign ch_gnt      = gnt_s;
  assign zero_last_s = (state_r == ZERO) && (zcnt_r == LAST_WORD);

  // Round-robin grant: first requester at or after rr_r; none while erasing or zeroize is raised.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_idx_s   = '0;
    gnt_s       = '0;
    sum_s       = '0;
    cand_s      = '0;
    if (rst && (state_r == IDLE) && !zeroize) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sum_s = {1'b0, rr_r} + CW1'(i);
        if (sum_s >= CW1'(NUM_CH)) begin
          sum_s = sum_s - CW1'(NUM_CH);
        end else begin
          sum_s = sum_s;
        end
        cand_s = sum_s[CW-1:0];
        if (!gnt_valid_s && ch_req[cand_s]) begin
          gnt_valid_s    = 1'b1;
          gnt_idx_s      = cand_s;
          gnt_s[cand_s]  = 1'b1;
        end else begin
          gnt_valid_s = gnt_valid_s;
        end
      end
    end else begin
      gnt_valid_s = 1'b0;
    end
  end

  // Route the granted channel's request fields.
  always_comb begin
    sel_addr_s  = '0;
    sel_we_s    = 1'b0;
    sel_lock_s  = 1'b0;
    sel_wdata_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_idx_s == CW'(i)) begin
        sel_addr_s  = ch_addr[i*AW +: AW];
        sel_we_s    = ch_we[i];
        sel_lock_s  = ch_lock[i];
        sel_wdata_s = ch_wdata[i*WIDTH +: WIDTH];
      end else begin
        sel_we_s = sel_we_s;
      end
    end
  end

  // Access checks in priority order: range, privilege, lock, debug denial.
  always_comb begin
    addr_ext_s = 32'(sel_addr_s);
    acc_err_s  = 1'b0;
    acc_code_s = CODE_RANGE;
    if (addr_ext_s >= 32'(LENGTH)) begin
      acc_err_s  = 1'b1;
      acc_code_s = CODE_RANGE;
    end else if (sel_lock_s) begin
      if (gnt_idx_s != CW'(0)) begin
        acc_err_s  = 1'b1;
        acc_code_s = CODE_PRIV;
      end else begin
        acc_err_s = 1'b0;
      end
    end else if (sel_we_s) begin
      if (lock_r[sel_addr_s]) begin
        acc_err_s  = 1'b1;
        acc_code_s = CODE_LOCKED;
      end else begin
        acc_err_s = 1'b0;
      end
    end else if ((lc_state == LC_DEBUG) && (addr_ext_s >= 32'(SECRET_BASE))) begin
      acc_err_s  = 1'b1;
      acc_code_s = CODE_DEBUG;
    end else begin
      acc_err_s = 1'b0;
    end
  end

  // Next-state logic for the idle/erase sequencer.
  always_comb begin
    state_s = state_r;
    zcnt_s  = zcnt_r;
    case (state_r)
      IDLE: begin
        zcnt_s = '0;
        if (zeroize) begin
          state_s = ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      ZERO: begin
        if (zcnt_r == LAST_WORD) begin
          state_s = IDLE;
          zcnt_s  = '0;
        end else begin
          zcnt_s  = zcnt_r + AW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        zcnt_s  = '0;
      end
    endcase
  end

  // Control state, lock bits and registered responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      zcnt_r    <= '0;
      rr_r      <= '0;
      lock_r    <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rsp_ch    <= '0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      busy      <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      state_r   <= state_s;
      zcnt_r    <= zcnt_s;
      busy      <= (state_s == ZERO);
      zero_done <= zero_last_s;
      rd_valid  <= 1'b0;
      err       <= 1'b0;
      if (zero_last_s) begin
        lock_r <= '0;
      end else if (gnt_valid_s && !acc_err_s && sel_lock_s) begin
        lock_r[sel_addr_s] <= 1'b1;
      end
      if (gnt_valid_s) begin
        rr_r <= (gnt_idx_s == CW'(NUM_CH - 1)) ? CW'(0) : gnt_idx_s + CW'(1);
        if (acc_err_s) begin
          err      <= 1'b1;
          err_code <= acc_code_s;
          rsp_ch   <= gnt_idx_s;
          rd_data  <= '0;
        end else if (!sel_we_s && !sel_lock_s) begin
          rd_valid <= 1'b1;
          rd_data  <= mem_r[sel_addr_s];
          rsp_ch   <= gnt_idx_s;
        end
      end
    end
  end

  // Array storage; contents intentionally survive reset, so an aborted erase leaves later words intact.
  always_ff @(posedge clk) begin
    if (state_r == ZERO) begin
      mem_r[zcnt_r] <= '0;
    end else if (gnt_valid_s && !acc_err_s && sel_we_s && !sel_lock_s) begin
      mem_r[sel_addr_s] <= sel_wdata_s;
    end
  end

endmodule

// File: tb/tb_mcse_secure_mem_ctrl.sv
// Self-checking bench for mcse_secure_mem_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model. LENGTH=12 makes addresses 12..15 reachable.
module tb_mcse_secure_mem_ctrl;

  localparam int         NCH = 3;
  localparam int         W   = 256;
  localparam int         LEN = 12;
  localparam int         SB  = 8;
  localparam int         AW  = 4;
  localparam int         CW  = 2;
  localparam logic [2:0] LCD = 3'd4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH-1:0]     ch_req, ch_we, ch_lock, ch_gnt;
  logic [NCH*AW-1:0]  ch_addr;
  logic [NCH*W-1:0]   ch_wdata;
  logic [2:0]         lc_state;
  logic               zeroize;
  logic [W-1:0]       rd_data;
  logic               rd_valid, err, busy, zero_done;
  logic [CW-1:0]      rsp_ch;
  logic [1:0]         err_code;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  logic [W-1:0]   mem_m [LEN];
  logic [LEN-1:0] lock_m;
  int             rr_m, zleft, exp_ch;
  logic           exp_valid, exp_err, exp_busy, exp_zd;
  logic [1:0]     exp_code;
  logic [W-1:0]   exp_data;

  // directed-access results
  logic           r_valid, r_err;
  logic [1:0]     r_code;
  logic [W-1:0]   r_data;
  logic [CW-1:0]  r_ch;

  mcse_secure_mem_ctrl #(
    .NUM_CH(NCH), .WIDTH(W), .LENGTH(LEN), .SECRET_BASE(SB), .LC_DEBUG(LCD)
  ) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_we(ch_we), .ch_lock(ch_lock),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_gnt(ch_gnt), .lc_state(lc_state),
    .zeroize(zeroize), .rd_data(rd_data), .rd_valid(rd_valid), .rsp_ch(rsp_ch),
    .err(err), .err_code(err_code), .busy(busy), .zero_done(zero_done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pat(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic compare_outputs(input bit full);
    chk("rd_valid", W'(rd_valid), W'(exp_valid));
    chk("err", W'(err), W'(exp_err));
    chk("busy", W'(busy), W'(exp_busy));
    chk("zero_done", W'(zero_done), W'(exp_zd));
    chk("rd_data", rd_data, exp_data);
    if (full || exp_valid || exp_err) chk("rsp_ch", W'(rsp_ch), W'(exp_ch));
    if (full || exp_err) chk("err_code", W'(err_code), W'(exp_code));
  endtask

  task automatic model_step();
    int g, a, e, c;
    logic we, lk;
    logic [NCH-1:0] eg;
    g = -1;
    if (zleft == 0 && !zeroize) begin
      for (int i = 0; i < NCH; i++) begin
        c = (rr_m + i) % NCH;
        if (g < 0 && ch_req[c]) g = c;
      end
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("ch_gnt", W'(ch_gnt), W'(eg));
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_zd    = 1'b0;
    if (zleft > 0) begin
      mem_m[LEN - zleft] = '0;
      zleft--;
      if (zleft == 0) begin
        lock_m = '0;
        exp_zd = 1'b1;
      end
    end else if (zeroize) begin
      zleft = LEN;
    end else if (g >= 0) begin
      a  = int'(ch_addr[g*AW +: AW]);
      we = ch_we[g];
      lk = ch_lock[g];
      rr_m = (g + 1) % NCH;
      if (a >= LEN) e = 0;
      else if (lk && g != 0) e = 3;
      else if (!lk && we && lock_m[a]) e = 1;
      else if (!lk && !we && lc_state == LCD && a >= SB) e = 2;
      else e = -1;
      if (e >= 0) begin
        exp_err  = 1'b1;
        exp_code = 2'(e);
        exp_ch   = g;
        exp_data = '0;
      end else if (lk) begin
        lock_m[a] = 1'b1;
      end else if (we) begin
        mem_m[a] = ch_wdata[g*W +: W];
      end else begin
        exp_valid = 1'b1;
        exp_data  = mem_m[a];
        exp_ch    = g;
      end
    end
    exp_busy = (zleft > 0);
  endtask

  // Compare every cycle at the falling edge, then advance the model across the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      lock_m = '0; rr_m = 0; zleft = 0; exp_ch = 0;
      exp_valid = 1'b0; exp_err = 1'b0; exp_busy = 1'b0; exp_zd = 1'b0;
      exp_code = 2'b00; exp_data = '0;
      compare_outputs(1'b1);
    end else begin
      compare_outputs(1'b0);
      model_step();
    end
  end

  task automatic access(input int c, input logic we, input logic lk, input int addr,
                        input logic [W-1:0] d);
    int n;
    @(posedge clk); #1;
    ch_we[c] = we; ch_lock[c] = lk;
    ch_addr[c*AW +: AW] = AW'(addr);
    ch_wdata[c*W +: W]  = d;
    ch_req[c] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ch_gnt[c] && n < 50);
    if (!ch_gnt[c]) begin
      n_checks++; n_errors++;
      $display("FAIL grant_timeout ch%0d got=none exp=grant", c);
    end
    @(posedge clk); #1;
    ch_req[c] = 1'b0;
    @(negedge clk);
    r_valid = rd_valid; r_err = err; r_code = err_code; r_data = rd_data; r_ch = rsp_ch;
  endtask

  task automatic wait_zero_done();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (zero_done) done = 1'b1;
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL zero_done_timeout got=0 exp=1");
    end
  endtask

  initial begin
    int busy_cnt;
    bit done;
    logic [NCH-1:0] g;
    logic [NCH-1:0] order [6];

    rst = 1'b0; ch_req = '0; ch_we = '0; ch_lock = '0; ch_addr = '0; ch_wdata = '0;
    lc_state = 3'd0; zeroize = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_rd_data", rd_data, '0);
    chk("reset_busy", W'(busy), W'(0));

    // start from a known array
    @(posedge clk); #1 zeroize = 1'b1;
    @(posedge clk); #1 zeroize = 1'b0;
    wait_zero_done();

    // 1: write then read from another channel
    access(0, 1'b1, 1'b0, 3, pat(8'hA5));
    access(1, 1'b0, 1'b0, 3, '0);
    chk("t1_valid", W'(r_valid), W'(1));
    chk("t1_data", r_data, pat(8'hA5));
    chk("t1_rsp_ch", W'(r_ch), W'(1));

    // 2: all channels contending, pointer first moved back to 0 by a ch2 grant
    access(2, 1'b0, 1'b0, 3, '0);
    @(posedge clk); #1;
    for (int c = 0; c < NCH; c++) ch_addr[c*AW +: AW] = AW'(3);
    ch_we = '0; ch_lock = '0; ch_req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      order[i] = ch_gnt;
    end
    @(posedge clk); #1 ch_req = '0;
    for (int i = 0; i < 6; i++) chk("t2_rr_order", W'(order[i]), W'(3'b001 << (i % 3)));

    // 3: locks
    access(0, 1'b1, 1'b0, 5, pat(8'h3C));
    access(0, 1'b0, 1'b1, 5, '0);
    chk("t3_lock_quiet", W'({r_valid, r_err}), W'(0));
    access(2, 1'b1, 1'b0, 5, pat(8'hFF));
    chk("t3_locked_err", W'(r_err), W'(1));
    chk("t3_locked_code", W'(r_code), W'(2'b01));
    chk("t3_locked_ch", W'(r_ch), W'(2));
    access(2, 1'b0, 1'b0, 5, '0);
    chk("t3_word_kept", r_data, pat(8'h3C));
    access(1, 1'b0, 1'b1, 5, '0);
    chk("t3_priv_code", W'({r_err, r_code}), W'(3'b111));
    access(0, 1'b0, 1'b1, 5, '0);
    chk("t3_relock_ok", W'(r_err), W'(0));

    // 4: debug lifecycle denial and out-of-range
    access(0, 1'b1, 1'b0, 9, pat(8'h5A));
    access(0, 1'b1, 1'b0, 2, pat(8'h11));
    access(0, 1'b1, 1'b0, 7, pat(8'h77));
    @(posedge clk); #1 lc_state = LCD;
    access(1, 1'b0, 1'b0, 9, '0);
    chk("t4_debug_code", W'({r_err, r_code}), W'(3'b110));
    chk("t4_debug_data", r_data, '0);
    access(1, 1'b0, 1'b0, 2, '0);
    chk("t4_public_data", r_data, pat(8'h11));
    access(1, 1'b0, 1'b0, 7, '0);
    chk("t4_below_secret", W'({r_valid, r_err}), W'(2'b10));
    access(1, 1'b0, 1'b0, 11, '0);
    chk("t4_last_secret", W'({r_err, r_code}), W'(3'b110));
    access(2, 1'b0, 1'b0, 12, '0);
    chk("t4_range_code", W'({r_err, r_code}), W'(3'b100));
    access(0, 1'b1, 1'b0, 9, pat(8'hAA));
    chk("t4_debug_write_ok", W'(r_err), W'(0));
    @(posedge clk); #1 lc_state = 3'd0;
    access(1, 1'b0, 1'b0, 9, '0);
    chk("t4_secret_after", r_data, pat(8'hAA));

    // 5: zeroize while ch1 waits
    @(posedge clk); #1;
    ch_we[1] = 1'b0; ch_lock[1] = 1'b0; ch_addr[1*AW +: AW] = AW'(3);
    ch_req[1] = 1'b1; zeroize = 1'b1;
    @(negedge clk);
    chk("t5_no_gnt_on_zeroize", W'(ch_gnt), W'(0));
    @(posedge clk); #1 zeroize = 1'b0;
    busy_cnt = 0; done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (zero_done) begin
        done = 1'b1;
        chk("t5_gnt_at_done", W'(ch_gnt), W'(3'b010));
      end else begin
        if (busy) busy_cnt++;
        chk("t5_gnt_while_busy", W'(ch_gnt), W'(0));
      end
    end
    chk("t5_done_seen", W'(done), W'(1));
    chk("t5_busy_cycles", W'(busy_cnt), W'(LEN));
    @(posedge clk); #1 ch_req[1] = 1'b0;
    @(negedge clk);
    chk("t5_read_after", {rd_data[W-3:0], rsp_ch}, W'(2'b01));
    chk("t5_read_valid", W'(rd_valid), W'(1));
    for (int k = 0; k < LEN; k++) begin
      access(0, 1'b0, 1'b0, k, '0);
      chk("t5_word_zero", r_data, '0);
    end
    access(2, 1'b1, 1'b0, 5, pat(8'h66));
    chk("t5_lock_cleared", W'(r_err), W'(0));

    // 6: reset aborts an erase in its fifth cycle
    for (int k = 0; k < LEN; k++) access(0, 1'b1, 1'b0, k, pat(8'(8'h40 + k)));
    @(posedge clk); #1 zeroize = 1'b1;
    @(posedge clk); #1 zeroize = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_busy_drop", W'(busy), W'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    access(0, 1'b0, 1'b0, 3, '0);
    chk("t6_word3_erased", r_data, '0);
    access(0, 1'b0, 1'b0, 4, '0);
    chk("t6_word4_kept", r_data, pat(8'h44));
    access(0, 1'b0, 1'b0, 11, '0);
    chk("t6_word11_kept", r_data, pat(8'h4B));

    // randomized traffic, requests held until granted
    g = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      g = ch_gnt;
      @(posedge clk); #1;
      for (int c = 0; c < NCH; c++) if (g[c]) ch_req[c] = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        if (!ch_req[c] && $urandom_range(0, 2) != 0) begin
          ch_we[c]   = 1'($urandom_range(0, 1));
          ch_lock[c] = ($urandom_range(0, 5) == 0);
          ch_addr[c*AW +: AW] = AW'($urandom_range(0, 15));
          for (int j = 0; j < 8; j++) ch_wdata[c*W + j*32 +: 32] = $urandom;
          ch_req[c] = 1'b1;
        end
      end
      zeroize  = ($urandom_range(0, 149) == 0);
      lc_state = ($urandom_range(0, 1) == 1) ? LCD : 3'($urandom_range(0, 7));
    end
    @(posedge clk); #1 ch_req = '0; zeroize = 1'b0;
    repeat (LEN + 4) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
